// File: rtl/multi_phase_auto_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multi_phase_auto_ctrl
// Brief    : N-phase signal sequencer (GREEN -> YELLOW -> optional all-red
//            CLEAR) with tick time-base, demand skipping and rest-in-green.
// Revision : 1.0 - initial release
// ============================================================================
module multi_phase_auto_ctrl #(
    parameter int NUM_PHASES = 4,
    parameter int TIME_W     = 7,
    parameter int PH_W       = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    tick,
    input  logic [TIME_W-1:0]       green_time,
    input  logic [TIME_W-1:0]       yellow_time,
    input  logic [TIME_W-1:0]       clear_time,
    input  logic                    skip_en,
    input  logic [NUM_PHASES-1:0]   demand,
    output logic [2*NUM_PHASES-1:0] lights,
    output logic [PH_W-1:0]         phase,
    output logic [1:0]              stage,
    output logic [TIME_W-1:0]       time_left,
    output logic                    phase_done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2,
        ST_CLEAR  = 2'd3
    } state_t;

    state_t                    r_state;
    logic [PH_W-1:0]           r_phase;
    logic [TIME_W-1:0]         r_time_left;
    logic [2*NUM_PHASES-1:0]   r_lights;
    logic                      r_phase_done;

    logic [TIME_W-1:0]         w_green_ld;
    logic [TIME_W-1:0]         w_yellow_ld;
    logic [PH_W-1:0]           w_inc_phase;
    logic [PH_W-1:0]           w_next_phase;
    logic [NUM_PHASES-1:0]     w_cur_onehot;
    logic                      w_rest;
    int                        w_dist;
    int                        w_best;

    assign w_green_ld   = (green_time  == '0) ? TIME_W'(1) : green_time;
    assign w_yellow_ld  = (yellow_time == '0) ? TIME_W'(1) : yellow_time;
    assign w_inc_phase  = (r_phase == PH_W'(NUM_PHASES - 1)) ? '0 : r_phase + PH_W'(1);
    assign w_cur_onehot = NUM_PHASES'(1) << r_phase;
    assign w_rest       = skip_en && ((demand & ~w_cur_onehot) == '0);

    // Demand search: distance from the current phase, with the current phase
    // itself ranked last (distance NUM_PHASES); nearest requester wins.
    always_comb begin
        w_next_phase = w_inc_phase;
        w_best       = NUM_PHASES + 1;
        w_dist       = 0;
        for (int j = 0; j < NUM_PHASES; j++) begin
            w_dist = (j + NUM_PHASES - int'(r_phase)) % NUM_PHASES;
            if (w_dist == 0) begin
                w_dist = NUM_PHASES;
            end
            if (skip_en && demand[j] && (w_dist < w_best)) begin
                w_best       = w_dist;
                w_next_phase = PH_W'(j);
            end
        end
    end

    function automatic logic [2*NUM_PHASES-1:0] f_lights(input state_t st,
                                                         input logic [PH_W-1:0] ph);
        f_lights = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (PH_W'(i) == ph) begin
                if (st == ST_GREEN) begin
                    f_lights[2*i +: 2] = 2'b10;
                end else if (st == ST_YELLOW) begin
                    f_lights[2*i +: 2] = 2'b01;
                end
            end
        end
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_phase      <= '0;
            r_time_left  <= '0;
            r_lights     <= '0;
            r_phase_done <= 1'b0;
        end else if (!enable) begin
            r_state      <= ST_IDLE;
            r_time_left  <= '0;
            r_lights     <= '0;
            r_phase_done <= 1'b0;
        end else begin
            r_phase_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // A tick coinciding with start-up is deliberately not counted.
                    r_state     <= ST_GREEN;
                    r_phase     <= '0;
                    r_time_left <= w_green_ld;
                    r_lights    <= f_lights(ST_GREEN, '0);
                end
                default: begin
                    if (tick) begin
                        if (r_time_left > TIME_W'(1)) begin
                            r_time_left <= r_time_left - TIME_W'(1);
                        end else begin
                            case (r_state)
                                ST_GREEN: begin
                                    if (w_rest) begin
                                        r_time_left <= w_green_ld;
                                    end else begin
                                        r_state     <= ST_YELLOW;
                                        r_time_left <= w_yellow_ld;
                                        r_lights    <= f_lights(ST_YELLOW, r_phase);
                                    end
                                end
                                ST_YELLOW: begin
                                    r_phase_done <= 1'b1;
                                    if (clear_time != '0) begin
                                        r_state     <= ST_CLEAR;
                                        r_time_left <= clear_time;
                                        r_lights    <= '0;
                                    end else begin
                                        r_state     <= ST_GREEN;
                                        r_phase     <= w_next_phase;
                                        r_time_left <= w_green_ld;
                                        r_lights    <= f_lights(ST_GREEN, w_next_phase);
                                    end
                                end
                                default: begin
                                    r_state     <= ST_GREEN;
                                    r_phase     <= w_next_phase;
                                    r_time_left <= w_green_ld;
                                    r_lights    <= f_lights(ST_GREEN, w_next_phase);
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign lights     = r_lights;
    assign phase      = r_phase;
    assign stage      = r_state;
    assign time_left  = r_time_left;
    assign phase_done = r_phase_done;

endmodule
`default_nettype wire

// File: tb/tb_multi_phase_auto_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_phase_auto_ctrl
// Brief    : Directed + randomized bench against a behavioural phase model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_phase_auto_ctrl;

    localparam int NP = 4;
    localparam int TW = 7;
    localparam int PW = 3;

    logic            clk = 1'b0;
    logic            reset, enable, tick, skip_en;
    logic [TW-1:0]   green_time, yellow_time, clear_time;
    logic [NP-1:0]   demand;
    logic [2*NP-1:0] lights;
    logic [PW-1:0]   phase;
    logic [1:0]      stage;
    logic [TW-1:0]   time_left;
    logic            phase_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // model state: stage 0..3, phase index, remaining ticks, done pulse
    int m_stage = 0, m_phase = 0, m_left = 0, m_done = 0;

    always #5 clk = ~clk;

    multi_phase_auto_ctrl #(.NUM_PHASES(NP), .TIME_W(TW), .PH_W(PW)) dut (
        .clk(clk), .reset(reset), .enable(enable), .tick(tick),
        .green_time(green_time), .yellow_time(yellow_time), .clear_time(clear_time),
        .skip_en(skip_en), .demand(demand), .lights(lights), .phase(phase),
        .stage(stage), .time_left(time_left), .phase_done(phase_done)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic int atleast1(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic int pick_next(input int cur);
        if (skip_en) begin
            for (int k = 1; k <= NP; k++) begin
                if (demand[(cur + k) % NP]) return (cur + k) % NP;
            end
        end
        return (cur + 1) % NP;
    endfunction

    function automatic int exp_lights();
        int v = 0;
        for (int i = 0; i < NP; i++) begin
            if (i == m_phase && m_stage == 1) v += 2 << (2 * i);
            if (i == m_phase && m_stage == 2) v += 1 << (2 * i);
        end
        return v;
    endfunction

    task automatic model_update();
        int others;
        if (reset) begin
            m_stage = 0; m_phase = 0; m_left = 0; m_done = 0;
        end else if (!enable) begin
            m_stage = 0; m_left = 0; m_done = 0;
        end else if (m_stage == 0) begin
            m_stage = 1; m_phase = 0; m_left = atleast1(int'(green_time)); m_done = 0;
        end else begin
            m_done = 0;
            if (tick) begin
                if (m_left > 1) begin
                    m_left--;
                end else if (m_stage == 1) begin
                    others = int'(demand) & ~(1 << m_phase);
                    if (skip_en && others == 0) begin
                        m_left = atleast1(int'(green_time));
                    end else begin
                        m_stage = 2; m_left = atleast1(int'(yellow_time));
                    end
                end else if (m_stage == 2) begin
                    m_done = 1;
                    if (clear_time != 0) begin
                        m_stage = 3; m_left = int'(clear_time);
                    end else begin
                        m_stage = 1; m_phase = pick_next(m_phase);
                        m_left = atleast1(int'(green_time));
                    end
                end else begin
                    m_stage = 1; m_phase = pick_next(m_phase);
                    m_left = atleast1(int'(green_time));
                end
            end
        end
    endtask

    task automatic step();
        int lit;
        model_update();
        @(posedge clk);
        #1;
        cyc++;
        chk("stage", int'(stage), m_stage);
        chk("phase", int'(phase), m_phase);
        chk("time_left", int'(time_left), m_left);
        chk("phase_done", int'(phase_done), m_done);
        chk("lights", int'(lights), exp_lights());
        lit = 0;
        for (int i = 0; i < NP; i++) begin
            if (lights[2*i +: 2] != 2'b00) lit++;
            chk("no_code11", int'(lights[2*i +: 2] == 2'b11), 0);
        end
        chk("one_lit", int'(lit <= 1), 1);
    endtask

    task automatic run_n(input int n, input int per);
        for (int i = 0; i < n; i++) begin
            tick = (per <= 1) ? 1'b1 : ((cyc % per) == 0);
            step();
        end
    endtask

    task automatic run_until(input int st, input int ph, input int maxc);
        int n = 0;
        tick = 1'b1;
        while (!(m_stage == st && m_phase == ph) && n < maxc) begin
            step();
            n++;
        end
        chk("reach_stage", int'(stage), st);
        chk("reach_phase", int'(phase), ph);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; tick = 1'b0; skip_en = 1'b0; demand = '0;
        green_time = 7'd3; yellow_time = 7'd2; clear_time = 7'd1;
        step();
        step();
        reset = 1'b0;
        step();

        // Basic rotation 0,1,2,3,0 with all-red clearance; start-up tick ignored
        enable = 1'b1;
        run_n(30, 1);

        // No clearance interval
        clear_time = 7'd0;
        run_n(20, 1);

        // Demand skipping: from phase 0 only phase 3 requested, then rest-in-green
        clear_time = 7'd1;
        run_until(1, 0, 40);
        skip_en = 1'b1; demand = 4'b1000;
        run_n(16, 1);
        demand = 4'b0001;
        run_n(14, 1);
        run_until(1, 0, 40);
        run_n(12, 1);

        // Sparse tick and mid-GREEN duration change
        skip_en = 1'b0; demand = '0; green_time = 7'd7;
        run_until(2, 0, 40);
        run_until(1, 1, 40);
        run_n(12, 5);
        green_time = 7'd2;
        run_n(90, 5);

        // Enable drop during phase 2 YELLOW, then re-enable
        green_time = 7'd3;
        run_until(2, 2, 60);
        enable = 1'b0;
        step();
        enable = 1'b1;
        run_n(4, 1);

        // Reset mid-CLEAR, then zero green duration
        run_until(3, 1, 60);
        reset = 1'b1;
        step();
        reset = 1'b0;
        green_time = 7'd0;
        run_n(20, 1);

        // Randomized operation
        for (int i = 0; i < 600; i++) begin
            reset       = ($urandom_range(0, 199) == 0);
            enable      = ($urandom_range(0, 59) != 0);
            tick        = ($urandom_range(0, 2) != 0);
            green_time  = TW'($urandom_range(0, 4));
            yellow_time = TW'($urandom_range(0, 3));
            clear_time  = TW'($urandom_range(0, 2));
            demand      = NP'($urandom);
            if ($urandom_range(0, 19) == 0) skip_en = ~skip_en;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multi_phase_auto_ctrl.md
Name: multi_phase_auto_ctrl

Overview:
- Parametrised successor of the two-lane auto-mode sequencer.
- Drives NUM_PHASES mutually exclusive signal phases in rotation: GREEN, then YELLOW, then optional all-red CLEAR, then the next phase.
- Adds a time-base strobe, demand-based phase skipping with rest-in-green, and a configurable all-red clearance interval.
- Sits between the mode selector and the lamp/display drivers.

Parameters:
- NUM_PHASES, 4, number of signal phases (2..8); exactly one phase is non-red at any time.
- TIME_W, 7, width of all durations and of the countdown.
- PH_W, 3, width of the phase index (must satisfy 2^PH_W >= NUM_PHASES).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = run the sequence; 0 = return to IDLE.
- tick  in  1  one-cycle time-base strobe (e.g. 1 Hz); countdowns advance only on tick.
- green_time  in  TIME_W  green duration in ticks.
- yellow_time  in  TIME_W  yellow duration in ticks.
- clear_time  in  TIME_W  all-red duration in ticks; 0 skips CLEAR.
- skip_en  in  1  enables demand-based skipping.
- demand  in  NUM_PHASES  per-phase request; bit i = phase i.
- lights  out  2*NUM_PHASES  per-phase code at bits [2i+1:2i]: 00 red, 01 yellow, 10 green; 11 is never driven.
- phase  out  PH_W  index of the current or last-served phase.
- stage  out  2  0 IDLE, 1 GREEN, 2 YELLOW, 3 CLEAR.
- time_left  out  TIME_W  ticks remaining in the current stage.
- phase_done  out  1  one-cycle pulse when a phase leaves YELLOW.

Behaviour:
- Reset (sync, highest priority): stage=IDLE, lights=all 00, phase=0, time_left=0, phase_done=0. Reset mid-operation returns to these values on the next edge.
- IDLE: all lamps red. enable=1 -> next cycle stage=GREEN, phase=0, time_left=max(green_time,1).
- enable=0 in any non-IDLE stage -> next cycle IDLE. phase keeps its value; lights, time_left and phase_done are as at reset.
- Stage entry loads time_left with the duration input sampled on that same edge; durations of 0 for GREEN or YELLOW are forced to 1. Changing a duration input mid-stage has no effect until the next entry into that stage.
- Without tick, all state holds. With tick and time_left>1, time_left decrements by 1.
- With tick and time_left==1, the stage ends:
  - GREEN -> YELLOW (load yellow). Rest-in-green exception: if skip_en=1 and no demand bit other than the current phase's is set, the phase stays GREEN and time_left reloads green_time.
  - YELLOW -> CLEAR (load clear_time) if clear_time!=0; otherwise the next phase enters GREEN directly. phase_done=1 on this edge only.
  - CLEAR -> next phase enters GREEN.
- Next phase:
  - skip_en=0: (phase+1) mod NUM_PHASES.
  - skip_en=1: first index with demand=1, searching phase+1, phase+2, ... wrapping, with the current phase checked last. If no demand bit is set, use (phase+1) mod NUM_PHASES.
  - demand is sampled on the transition edge.
- lights is a registered decode of (stage, phase): current phase 10 in GREEN and 01 in YELLOW; all others 00; all 00 in CLEAR and IDLE. It changes on the same edge as stage.
- Invariant: at most one phase non-red in any cycle; no GREEN->GREEN handoff between different phases without an intervening YELLOW.
- phase wraps from NUM_PHASES-1 to 0; indices >= NUM_PHASES are never produced.
- Simultaneous tick and enable 0->1 from IDLE: GREEN is entered and that tick is not counted.

Test Plan:
- Reset, then enable=1, NUM_PHASES=4, green=3, yellow=2, clear=1, skip_en=0, tick every cycle -> phase sequence 0,1,2,3,0; each phase shows 3 cycles green (time_left 3,2,1), 2 yellow, 1 all-red; phase_done pulses once per phase.
- clear_time=0 -> YELLOW of phase 1 goes straight to GREEN of phase 2; lights show no all-red cycle and never two non-red phases.
- skip_en=1, demand=4'b1000 while phase 0 is GREEN -> after 0's yellow/clear, phase 3 is served. With demand=4'b0001 during phase 0 GREEN -> phase 0 rests in green, time_left reloads to 3 on each expiry.
- tick asserted every 5th cycle -> time_left changes only on tick cycles; green_time changed 7->2 mid-GREEN -> current count unaffected, next GREEN loads 2.
- enable dropped during YELLOW of phase 2 -> next cycle stage=0, lights=0, phase stays 2; re-enable -> phase 0 GREEN.
- reset asserted mid-CLEAR -> next cycle all outputs at reset values; green_time=0 -> GREEN lasts exactly 1 tick.
